// File: rtl/ai_core_pkg.sv
// Shared helpers for the AI core datapath: saturation bounds and sign extension.
// Widths handled by these helpers are limited to 32 bits.
package ai_core_pkg;

  localparam int unsigned HELPER_W = 32;

  function automatic logic [HELPER_W-1:0] sat_max(input int unsigned width);
    return (32'd1 << (width - 1)) - 32'd1;
  endfunction

  function automatic logic [HELPER_W-1:0] sat_min(input int unsigned width);
    return ~sat_max(width);
  endfunction

  // Replicates bit (width-1) of val into every higher bit position.
  function automatic logic [HELPER_W-1:0] sext(input logic [HELPER_W-1:0] val,
                                               input int unsigned width);
    logic [HELPER_W-1:0] r;
    r = val;
    for (int b = 0; b < HELPER_W; b++) begin
      if (b >= int'(width)) r[b] = val[width-1];
    end
    return r;
  endfunction

endpackage

// File: rtl/accum_lane.sv
// One accumulator lane: clear-on-first mux, adder and optional saturation.
// Saturation is enabled by the ACCUM_SAT_EN macro.
module accum_lane
  import ai_core_pkg::*;
#(
  parameter int IN_SIZE  = 8,
  parameter int ACC_SIZE = 16
) (
  input  logic                first_i,
  input  logic [ACC_SIZE-1:0] acc_i,
  input  logic [IN_SIZE-1:0]  data_i,
`ifdef ACCUM_SAT_EN
  output logic                ovf_o,
`endif
  output logic [ACC_SIZE-1:0] nxt_o
);

  logic [ACC_SIZE-1:0] w_base;
  logic [ACC_SIZE-1:0] w_ext;
  logic [ACC_SIZE-1:0] w_raw;

  assign w_base = first_i ? '0 : acc_i;
  assign w_ext  = ACC_SIZE'(sext(HELPER_W'(data_i), IN_SIZE));
  assign w_raw  = w_base + w_ext;

`ifdef ACCUM_SAT_EN
  localparam logic [ACC_SIZE-1:0] MAX_VAL = ACC_SIZE'(sat_max(ACC_SIZE));
  localparam logic [ACC_SIZE-1:0] MIN_VAL = ACC_SIZE'(sat_min(ACC_SIZE));

  // Overflow only when both operands share a sign the result does not.
  assign ovf_o = (w_base[ACC_SIZE-1] == w_ext[ACC_SIZE-1]) &&
                 (w_raw[ACC_SIZE-1] != w_base[ACC_SIZE-1]);
  assign nxt_o = ovf_o ? (w_base[ACC_SIZE-1] ? MIN_VAL : MAX_VAL) : w_raw;
`else
  assign nxt_o = w_raw;
`endif

endmodule

// File: rtl/accum_n.sv
// Multi-lane accumulator summing len_i beats per group into a one-entry output slot.
// Optional per-lane saturation and overflow flag via the ACCUM_SAT_EN macro.
module accum_n
  import ai_core_pkg::*;
#(
  parameter int IN_NUM   = 2,
  parameter int IN_SIZE  = 8,
  parameter int ACC_SIZE = 16,
  parameter int CNT_W    = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [IN_SIZE-1:0]  data_i [0:IN_NUM-1],
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [CNT_W-1:0]    len_i,
  output logic [ACC_SIZE-1:0] sum_o  [0:IN_NUM-1],
  output logic                valid_o,
  input  logic                ready_i,
  output logic                ovf_o
);

  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    r_len;
  logic [ACC_SIZE-1:0] r_acc [0:IN_NUM-1];
  logic [ACC_SIZE-1:0] r_sum [0:IN_NUM-1];
  logic                r_valid;

  logic                w_first;
  logic [CNT_W-1:0]    w_lenEff;
  logic                w_isLast;
  logic                w_accept;
  logic [ACC_SIZE-1:0] w_nxt [0:IN_NUM-1];

  assign w_first  = (r_cnt == '0);
  assign w_lenEff = w_first ? ((len_i == '0) ? CNT_W'(1) : len_i) : r_len;
  assign w_isLast = (r_cnt == w_lenEff - CNT_W'(1));
  // Only the closing beat of a group needs the output slot to be free.
  assign ready_o  = !w_isLast || !r_valid || ready_i;
  assign w_accept = valid_i && ready_o;

`ifdef ACCUM_SAT_EN
  logic [IN_NUM-1:0] w_laneOvf;
`endif

  for (genvar g = 0; g < IN_NUM; g++) begin : g_lane
    accum_lane #(
      .IN_SIZE (IN_SIZE),
      .ACC_SIZE(ACC_SIZE)
    ) u_lane (
      .first_i(w_first),
      .acc_i  (r_acc[g]),
      .data_i (data_i[g]),
`ifdef ACCUM_SAT_EN
      .ovf_o  (w_laneOvf[g]),
`endif
      .nxt_o  (w_nxt[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt   <= '0;
      r_len   <= '0;
      r_acc   <= '{default: '0};
      r_sum   <= '{default: '0};
      r_valid <= 1'b0;
    end else begin
      // A pop clears the slot unless a last-beat load refills it below.
      if (r_valid && ready_i) r_valid <= 1'b0;
      if (w_accept) begin
        if (w_isLast) begin
          r_sum   <= w_nxt;
          r_valid <= 1'b1;
          r_cnt   <= '0;
        end else begin
          r_acc <= w_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_first) r_len <= w_lenEff;
        end
      end
    end
  end

`ifdef ACCUM_SAT_EN
  logic r_grpOvf;
  logic r_ovf;
  logic w_ovfSoFar;

  assign w_ovfSoFar = (w_first ? 1'b0 : r_grpOvf) | (|w_laneOvf);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_grpOvf <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      if (w_isLast) r_ovf <= w_ovfSoFar;
      else          r_grpOvf <= w_ovfSoFar;
    end
  end

  assign ovf_o = r_ovf;
`else
  assign ovf_o = 1'b0;
`endif

  assign sum_o   = r_sum;
  assign valid_o = r_valid;

endmodule
